// File: rtl/ann_result_collector_if.sv
// Output-FIFO read port and result-RAM write port of ann_result_collector.
// master = collector side, slave = FIFO/RAM side.
interface ann_result_collector_if #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 9
);
  logic                  out_fifo_rempty_n;
  logic [DATA_WIDTH-1:0] out_fifo_rdata;
  logic                  out_fifo_deq;
  logic                  res_wen;
  logic [ADDR_WIDTH-1:0] res_waddr;
  logic [DATA_WIDTH-1:0] res_wdata;

  modport master (
    input  out_fifo_rempty_n, out_fifo_rdata,
    output out_fifo_deq, res_wen, res_waddr, res_wdata
  );

  modport slave (
    output out_fifo_rempty_n, out_fifo_rdata,
    input  out_fifo_deq, res_wen, res_waddr, res_wdata
  );
endinterface

// File: rtl/ann_result_collector.sv
// Drains blocked-scan-order results from the accelerator FIFO into a row-major result RAM.
// Optional sticky surplus-data flag built only when ANN_COLLECT_OVERRUN_CHECK_EN is defined.
module ann_result_collector #(
  parameter int DATA_WIDTH = 11,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          start_i,
  ann_result_collector_if.master        fifo,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overrun_o
);

  localparam int HALF  = ROW_SIZE / 2;
  localparam int XBLK  = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int LASTW = HALF - (XBLK - 1) * BLOCKING;
  localparam int XW    = (XBLK > 1) ? $clog2(XBLK) : 1;
  localparam int YW    = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int XIW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  px_q, px_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [XIW-1:0]        xi_q, xi_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] blk_base_q, blk_base_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  deq;
  logic                  start_ok;
  logic                  x_last, y_last, xi_last, last_deq;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign start_ok = start_i && (state_q != COLLECT);
  assign x_last   = (x_q == XW'(XBLK - 1));
  assign y_last   = (y_q == YW'(COL_SIZE - 1));
  assign xi_last  = x_last ? (xi_q == XIW'(LASTW - 1)) : (xi_q == XIW'(BLOCKING - 1));
  assign last_deq = deq && px_q && x_last && y_last && xi_last;
  // Row base tracks y*ROW_SIZE, block base tracks px*HALF + x*BLOCKING.
  assign cur_addr = row_base_q + blk_base_q + ADDR_WIDTH'(xi_q);

  // State register and all datapath flops share one synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst_i) begin
      state_q    <= IDLE;
      px_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      xi_q       <= '0;
      row_base_q <= '0;
      blk_base_q <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xi_q       <= xi_d;
      row_base_q <= row_base_d;
      blk_base_q <= blk_base_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_i)  state_d = COLLECT;
      COLLECT:    if (last_deq) state_d = DONE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    deq    = (state_q == COLLECT) && fifo.out_fifo_rempty_n;
    busy_o = (state_q == COLLECT);
    done_o = (state_q == DONE);
  end

  // Counter nest, innermost first: xi, y, x, px.
  always_comb begin
    px_d       = px_q;
    x_d        = x_q;
    y_d        = y_q;
    xi_d       = xi_q;
    row_base_d = row_base_q;
    blk_base_d = blk_base_q;
    if (start_ok) begin
      px_d       = 1'b0;
      x_d        = '0;
      y_d        = '0;
      xi_d       = '0;
      row_base_d = '0;
      blk_base_d = '0;
    end else if (deq) begin
      if (!xi_last) begin
        xi_d = xi_q + 1'b1;
      end else begin
        xi_d = '0;
        if (!y_last) begin
          y_d        = y_q + 1'b1;
          row_base_d = row_base_q + ADDR_WIDTH'(ROW_SIZE);
        end else begin
          y_d        = '0;
          row_base_d = '0;
          if (!x_last) begin
            x_d        = x_q + 1'b1;
            blk_base_d = blk_base_q + ADDR_WIDTH'(BLOCKING);
          end else begin
            x_d        = '0;
            px_d       = ~px_q;
            blk_base_d = px_q ? '0 : ADDR_WIDTH'(HALF);
          end
        end
      end
    end
  end

  always_comb begin
    wen_d   = deq;
    waddr_d = deq ? cur_addr : waddr_q;
    wdata_d = deq ? fifo.out_fifo_rdata : wdata_q;
  end

  assign fifo.out_fifo_deq = deq;
  assign fifo.res_wen      = wen_q;
  assign fifo.res_waddr    = waddr_q;
  assign fifo.res_wdata    = wdata_q;

`ifdef ANN_COLLECT_OVERRUN_CHECK_EN
  logic overrun_q, overrun_d;

  // start_i wins over a same-cycle set so data already queued at arm time is not flagged.
  always_comb begin
    overrun_d = overrun_q;
    if (start_i)
      overrun_d = 1'b0;
    else if (fifo.out_fifo_rempty_n && (state_q != COLLECT))
      overrun_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_ann_result_collector.sv
// Scoreboard bench for ann_result_collector: expected (addr,data) pairs are queued on each
// dequeue and popped against the registered RAM write one cycle later.
module tb_ann_result_collector;
  localparam int DW    = 11;
  localparam int ROW   = 26;
  localparam int COL   = 19;
  localparam int BLK   = 4;
  localparam int NUM   = ROW * COL;
  localparam int AW    = $clog2(NUM);
  localparam int HALF  = ROW / 2;
  localparam int XBLK  = (HALF + BLK - 1) / BLK;
  localparam int LASTW = HALF - (XBLK - 1) * BLK;

  typedef enum {M_IDLE, M_COLLECT, M_DONE} mstate_e;
  typedef struct {int addr; int data;} wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, overrun;

  ann_result_collector_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif ();

  ann_result_collector #(
    .DATA_WIDTH(DW), .ROW_SIZE(ROW), .COL_SIZE(COL), .BLOCKING(BLK),
    .NUM_QUERYS(NUM), .ADDR_WIDTH(AW)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start_i  (start),
    .fifo     (fif),
    .busy_o   (busy),
    .done_o   (done),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int      vectors = 0;
  int      miscompares = 0;
  mstate_e mst = M_IDLE;
  bit      ov = 1'b0;
  int      head = 0;
  wr_t     sb[$];
  int      seen[NUM];
  int      addr_of[NUM];

  // Reference mapping from scan index to row-major address, derived by division.
  function automatic int model_addr(input int k);
    int px, r, x, bw, off;
    px  = k / (NUM / 2);
    r   = k % (NUM / 2);
    x   = r / (COL * BLK);
    bw  = (x == XBLK - 1) ? LASTW : BLK;
    off = r - x * COL * BLK;
    return px * HALF + (off / bw) * ROW + x * BLK + (off % bw);
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic step(input bit valid, input bit st, input bit rs, input bit chk);
    wr_t w;
    bit  exp_wen;
    bit  exp_deq;
    fif.out_fifo_rempty_n = valid;
    fif.out_fifo_rdata    = DW'(head);
    start = st;
    rst   = rs;
    @(negedge clk);
    exp_wen = (sb.size() > 0);
    exp_deq = (mst == M_COLLECT) && valid;
    if (chk) begin
      vectors++;
      if (fif.res_wen !== exp_wen) begin
        miscompares++;
        $display("FAIL res_wen: got %b want %b (head %0d)", fif.res_wen, exp_wen, head);
      end
      if (fif.res_wen === 1'b1 && exp_wen) begin
        w = sb.pop_front();
        vectors++;
        if (fif.res_waddr !== AW'(w.addr) || fif.res_wdata !== DW'(w.data)) begin
          miscompares++;
          $display("FAIL write_pair: got addr %0d data %0d want addr %0d data %0d",
                   fif.res_waddr, fif.res_wdata, w.addr, w.data);
        end
        if (int'(fif.res_waddr) < NUM) seen[int'(fif.res_waddr)]++;
        addr_of[w.data] = int'(fif.res_waddr);
      end
      vectors++;
      if (fif.out_fifo_deq !== exp_deq) begin
        miscompares++;
        $display("FAIL out_fifo_deq: got %b want %b (head %0d)", fif.out_fifo_deq, exp_deq, head);
      end
      vectors++;
      if (busy !== (mst == M_COLLECT)) begin
        miscompares++;
        $display("FAIL busy_o: got %b want %b (head %0d)", busy, mst == M_COLLECT, head);
      end
      vectors++;
      if (done !== (mst == M_DONE)) begin
        miscompares++;
        $display("FAIL done_o: got %b want %b (head %0d)", done, mst == M_DONE, head);
      end
      vectors++;
      if (overrun !== ov) begin
        miscompares++;
        $display("FAIL overrun_o: got %b want %b", overrun, ov);
      end
    end
    sb.delete();
    if (exp_wen && !(chk && fif.res_wen === 1'b1)) sb.delete();
    if (exp_deq) begin
      sb.push_back('{model_addr(head), head});
      if (head == NUM - 1) mst = M_DONE;
      head++;
    end
`ifdef ANN_COLLECT_OVERRUN_CHECK_EN
    if (st) ov = 1'b0;
    else if (valid && mst != M_COLLECT && !exp_deq) ov = 1'b1;
`endif
    if (rs) begin
      mst = M_IDLE;
      ov  = 1'b0;
      sb.delete();
    end else if (st && mst != M_COLLECT) begin
      mst  = M_COLLECT;
      head = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Runs the FIFO until the model leaves COLLECT; optional start/reset injection at a head index.
  task automatic collect(input int pct, input int start_at, input int rst_at);
    int budget;
    bit v, s, r, injected;
    budget   = 20000;
    injected = 1'b0;
    while (mst == M_COLLECT && budget > 0) begin
      v = ($urandom_range(99) < pct);
      s = (head == start_at) && !injected;
      r = (head == rst_at);
      if (s) injected = 1'b1;
      step(v, s, r, 1'b1);
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL collect_timeout: got head %0d want %0d", head, NUM);
    end else if (rst_at < 0) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic begin_pass();
    for (int i = 0; i < NUM; i++) begin
      seen[i]    = 0;
      addr_of[i] = -1;
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic check_cover(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < NUM; i++) if (seen[i] != 1) bad++;
    vectors++;
    if (bad != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_cover: got %0d bad addresses, %0d pending writes; want 0 and 0",
               name, bad, sb.size());
    end
  endtask

  task automatic check_table(input string name);
    int ks[7];
    int as[7];
    ks = '{0, 3, 4, 228, 229, 247, 493};
    as = '{0, 3, 26, 12, 38, 13, 493};
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (addr_of[ks[i]] != as[i]) begin
        miscompares++;
        $display("FAIL %s_addr_k%0d: got %0d want %0d", name, ks[i], addr_of[ks[i]], as[i]);
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (fif.res_waddr !== '0 || fif.res_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_wr_port: got addr %0d data %0d want 0 0", fif.res_waddr, fif.res_wdata);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_full_pass();
    begin_pass();
    collect(100, -1, -1);
    check_table("full");
    check_cover("full");
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stalled_pass();
    begin_pass();
    collect(30, -1, -1);
    check_table("stalled");
    check_cover("stalled");
  endtask

  task automatic test_reset_mid_pass();
    begin_pass();
    collect(100, -1, 100);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    begin_pass();
    collect(100, -1, -1);
    vectors++;
    if (addr_of[0] != 0) begin
      miscompares++;
      $display("FAIL reset_mid_first_addr: got %0d want 0", addr_of[0]);
    end
    check_cover("reset_mid");
  endtask

  task automatic test_start_in_collect();
    begin_pass();
    collect(100, 50, -1);
    check_cover("start_ignored");
    begin_pass();
    collect(100, -1, -1);
    vectors++;
    if (addr_of[0] != 0) begin
      miscompares++;
      $display("FAIL restart_first_addr: got %0d want 0", addr_of[0]);
    end
    check_cover("restart");
  endtask

  task automatic test_overrun();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
`ifdef ANN_COLLECT_OVERRUN_CHECK_EN
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
`else
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_tied: got %b want 0", overrun);
    end
`endif
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    fif.out_fifo_rempty_n = 1'b0;
    fif.out_fifo_rdata    = '0;
    test_reset();
    test_full_pass();
    test_stalled_pass();
    test_reset_mid_pass();
    test_start_in_collect();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
